audio_adc_rx: RTL and testbench

Receive-side serial audio deserializer for the WM8731 codec; it is the ADC-path counterpart of the DAC serializer in Sound_Top. It captures ADCDAT on codec BCLK in DSP mode (the same 32-BCLK frame marked by a one-BCLK LRC pulse that the DAC side uses) and emits parallel 16-bit left/right sample pairs on a valid/ready handshake. All logic runs in the clk domain. bclk, adc_lrck and adc_dat are oversampled through synchronizers.

---
 rtl/audio_codec_pkg.sv | 37 +++
 rtl/audio_adc_rx_sync.sv | 47 ++++
 rtl/audio_adc_rx.sv | 156 +++++++++++++++
 tb/tb_audio_adc_rx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/audio_codec_pkg.sv
// Shared definitions for the WM8731 audio codec path: frame geometry,
// ADC receiver state encoding and the codec control register map used by
// the configuration sequencer.
package audio_codec_pkg;

    localparam int SAMPLE_BITS = 16;
    localparam int FRAME_BITS  = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        SHIFT     = 2'd2
    } rx_state_t;

    // WM8731 control register addresses (7-bit address, 9-bit data words)
    localparam logic [6:0] REG_LEFT_LINE_IN  = 7'h00;
    localparam logic [6:0] REG_RIGHT_LINE_IN = 7'h01;
    localparam logic [6:0] REG_LEFT_HP_OUT   = 7'h02;
    localparam logic [6:0] REG_RIGHT_HP_OUT  = 7'h03;
    localparam logic [6:0] REG_ANALOG_PATH   = 7'h04;
    localparam logic [6:0] REG_DIGITAL_PATH  = 7'h05;
    localparam logic [6:0] REG_POWER_DOWN    = 7'h06;
    localparam logic [6:0] REG_DIGITAL_IF    = 7'h07;
    localparam logic [6:0] REG_SAMPLING      = 7'h08;
    localparam logic [6:0] REG_ACTIVE        = 7'h09;
    localparam logic [6:0] REG_RESET         = 7'h0F;

    // Digital interface value: DSP mode, 16-bit words, slave
    localparam logic [8:0] DIGITAL_IF_DSP16  = 9'h003;

    // Pack a register address and data into the 16-bit control word
    function automatic logic [15:0] codec_cmd(input logic [6:0] addr,
                                              input logic [8:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/audio_adc_rx_sync.sv
// Multi-flop synchronizer for one edge-detected input plus companion
// inputs that share the exact same delay, so a registered rise pulse and
// the companion samples arrive in the same clk cycle.
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2,
    parameter int AUX_W       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             edge_i,
    input  logic [AUX_W-1:0] aux_i,
    output logic             rise_o,
    output logic [AUX_W-1:0] aux_o
);

    logic [SYNC_STAGES-1:0] edge_sync_q;
    logic [AUX_W-1:0]       aux_sync_q [SYNC_STAGES];
    logic                   edge_prev_q;
    logic                   rise_q;
    logic [AUX_W-1:0]       aux_q;

    // Synchronizer chains, rise detect and aligned companion register
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_sync_q <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                aux_sync_q[s] <= '0;
            end
            edge_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            aux_q       <= '0;
        end else begin
            edge_sync_q   <= {edge_sync_q[SYNC_STAGES-2:0], edge_i};
            aux_sync_q[0] <= aux_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                aux_sync_q[s] <= aux_sync_q[s-1];
            end
            edge_prev_q <= edge_sync_q[SYNC_STAGES-1];
            rise_q      <= edge_sync_q[SYNC_STAGES-1] & ~edge_prev_q;
            aux_q       <= aux_sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = rise_q;
    assign aux_o  = aux_q;

endmodule

// File: rtl/audio_adc_rx.sv
// WM8731 ADC-path receiver: deserializes DSP-mode ADCDAT frames (one-BCLK
// LRC pulse, then left then right sample MSB first) on oversampled BCLK
// rising edges and presents left/right pairs on a valid/ready handshake.
module audio_adc_rx #(
    parameter int SAMPLE_BITS = audio_codec_pkg::SAMPLE_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   bclk,
    input  logic                   adc_lrck,
    input  logic                   adc_dat,
    output logic [SAMPLE_BITS-1:0] sample_left,
    output logic [SAMPLE_BITS-1:0] sample_right,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic                   overrun,
    output logic                   frame_error
);

    import audio_codec_pkg::*;

    localparam int          FRAME_LEN = 2 * SAMPLE_BITS;
    localparam logic [5:0]  LAST_BIT  = 6'(FRAME_LEN - 1);

    logic                   rise_s;
    logic [1:0]             aux_s;
    logic                   lrck_s;
    logic                   dat_s;
    logic [FRAME_LEN-1:0]   shift_d;
    logic                   frame_done_s;
    logic                   xfer_s;

    rx_state_t              state_q;
    logic [5:0]             bit_cnt_q;
    logic [FRAME_LEN-1:0]   shift_q;
    logic [SAMPLE_BITS-1:0] left_q;
    logic [SAMPLE_BITS-1:0] right_q;
    logic                   valid_q;
    logic                   overrun_q;
    logic                   frame_error_q;

    sync_rise_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .AUX_W       (2)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .edge_i (bclk),
        .aux_i  ({adc_lrck, adc_dat}),
        .rise_o (rise_s),
        .aux_o  (aux_s)
    );

    assign lrck_s = aux_s[1];
    assign dat_s  = aux_s[0];

    // Next shift value, frame-complete and handshake-transfer qualifiers
    always_comb begin
        shift_d      = {shift_q[FRAME_LEN-2:0], dat_s};
        frame_done_s = 1'b0;
        if (enable && (state_q == SHIFT) && rise_s && !lrck_s
            && (bit_cnt_q == LAST_BIT)) begin
            frame_done_s = 1'b1;
        end else begin
            frame_done_s = 1'b0;
        end
        xfer_s = valid_q & sample_ready;
    end

    // Receiver FSM, bit counter, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 6'd0;
            shift_q       <= '0;
            left_q        <= '0;
            right_q       <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            frame_error_q <= 1'b0;

            // Output pair: a completed frame is taken only if the slot is
            // free or being emptied this cycle; otherwise it is dropped.
            if (frame_done_s) begin
                if (!valid_q || sample_ready) begin
                    left_q  <= shift_d[FRAME_LEN-1:SAMPLE_BITS];
                    right_q <= shift_d[SAMPLE_BITS-1:0];
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (xfer_s) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_q;
            end

            // Disabling the receiver aborts any frame and clears overrun;
            // a pending pair survives until it is taken.
            if (!enable) begin
                state_q   <= IDLE;
                bit_cnt_q <= 6'd0;
                shift_q   <= '0;
                overrun_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= WAIT_SYNC;
                    end
                    WAIT_SYNC: begin
                        if (rise_s && lrck_s) begin
                            bit_cnt_q <= 6'd0;
                            shift_q   <= '0;
                            state_q   <= SHIFT;
                        end else begin
                            state_q <= WAIT_SYNC;
                        end
                    end
                    SHIFT: begin
                        if (rise_s && lrck_s) begin
                            // Sync pulse inside a frame: restart, drop the bit
                            frame_error_q <= 1'b1;
                            bit_cnt_q     <= 6'd0;
                            shift_q       <= '0;
                            state_q       <= SHIFT;
                        end else if (rise_s) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= WAIT_SYNC;
                            end else begin
                                state_q <= SHIFT;
                            end
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sample_left  = left_q;
    assign sample_right = right_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Scoreboard bench for audio_adc_rx: stimulus pushes expected pairs, a
// negedge monitor pops and compares on every handshake transfer.
module tb_audio_adc_rx;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        bclk;
    logic        adc_lrck;
    logic        adc_dat;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;
    logic        frame_error;

    int          n_cmp;
    int          n_bad;
    int          fe_cnt;
    logic [31:0] exp_q [$];
    logic        held;
    logic [31:0] held_pair;

    audio_adc_rx dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .bclk         (bclk),
        .adc_lrck     (adc_lrck),
        .adc_dat      (adc_dat),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_error  (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One BCLK period = 8 clk: low half then high half; rise in the middle
    task automatic send_bit(input logic l, input logic d);
        bclk = 1'b0; adc_lrck = l; adc_dat = d;
        repeat (4) @(posedge clk);
        #1;
        bclk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        logic [31:0] w;
        w = {l, r};
        send_bit(1'b1, 1'b0);
        for (int i = 31; i >= 0; i--) send_bit(1'b0, w[i]);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every transferred pair and watch stall stability
    always @(negedge clk) begin
        logic [31:0] e;
        if (frame_error) fe_cnt++;
        if (held && sample_valid) begin
            n_cmp++;
            if ({sample_left, sample_right} !== held_pair) begin
                n_bad++;
                $display("FAIL stall_stable: got %h expected %h", {sample_left, sample_right}, held_pair);
            end
        end
        if (sample_valid && sample_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pair: got %h expected none", {sample_left, sample_right});
            end else begin
                e = exp_q.pop_front();
                if ({sample_left, sample_right} !== e) begin
                    n_bad++;
                    $display("FAIL pair: got %h expected %h", {sample_left, sample_right}, e);
                end
            end
        end
        held      = sample_valid && !sample_ready && !reset;
        held_pair = {sample_left, sample_right};
    end

    initial begin
        logic [15:0] pat [4];
        n_cmp = 0; n_bad = 0; fe_cnt = 0; held = 1'b0; held_pair = '0;
        reset = 1'b1; enable = 1'b0; bclk = 1'b0; adc_lrck = 1'b0;
        adc_dat = 1'b0; sample_ready = 1'b1;
        wait_clks(3);
        @(negedge clk);
        check("reset_pair", {sample_left, sample_right}, 32'h0);
        check("reset_flags", {29'd0, sample_valid, overrun, frame_error}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; enable = 1'b1;
        wait_clks(4);

        // 1. basic frame
        exp_q.push_back({16'hA5C3, 16'h1234});
        send_frame(16'hA5C3, 16'h1234);
        wait_clks(10);
        check("t1_overrun", {31'd0, overrun}, 32'd0);

        // 2. back-to-back frames
        pat[0] = 16'h0001; pat[1] = 16'h8000; pat[2] = 16'hFFFF; pat[3] = 16'h7FFE;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({pat[i], ~pat[i]});
            send_frame(pat[i], ~pat[i]);
        end
        wait_clks(10);
        check("t2_frame_error_count", fe_cnt, 0);

        // 3. backpressure: second frame dropped, overrun sticky
        sample_ready = 1'b0;
        exp_q.push_back({16'h1111, 16'h2222});
        send_frame(16'h1111, 16'h2222);
        send_frame(16'h3333, 16'h4444);
        wait_clks(10);
        check("t3_overrun_set", {31'd0, overrun}, 32'd1);
        sample_ready = 1'b1;
        wait_clks(10);
        check("t3_overrun_sticky", {31'd0, overrun}, 32'd1);

        // 4. LRC pulse after 10 bits of a frame
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1);
        exp_q.push_back({16'hBEEF, 16'hCAFE});
        send_frame(16'hBEEF, 16'hCAFE);
        wait_clks(10);
        check("t4_frame_error_count", fe_cnt, 1);

        // 5a. enable drop after 20 bits
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b1);
        bclk = 1'b0;
        wait_clks(4);
        enable = 1'b0;
        wait_clks(4);
        @(negedge clk);
        check("t5_overrun_cleared", {31'd0, overrun}, 32'd0);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_clks(4);
        exp_q.push_back({16'h5555, 16'hAAAA});
        send_frame(16'h5555, 16'hAAAA);
        wait_clks(10);

        // 5b. reset mid-frame with a pending pair
        sample_ready = 1'b0;
        send_frame(16'h1357, 16'h2468);
        wait_clks(10);
        check("t5_pending_valid", {31'd0, sample_valid}, 32'd1);
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
        bclk = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_reset_pair", {sample_left, sample_right}, 32'h0);
        check("t5_reset_flags", {29'd0, sample_valid, overrun, frame_error}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; sample_ready = 1'b1;
        wait_clks(4);

        // 6. pre-sync garbage then a valid frame
        for (int i = 0; i < 40; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
        exp_q.push_back({16'h0F0F, 16'hF0F0});
        send_frame(16'h0F0F, 16'hF0F0);
        wait_clks(20);

        check("queue_drained", exp_q.size(), 0);
        check("final_frame_error_count", fe_cnt, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
